// File: rtl/csr_pkg.sv
`default_nettype none
// =====================================================================
// Package  : csr_pkg
// Brief    : CSR index map, write-op encodings and the write combine rule
// Revision : 1.0
// =====================================================================
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE              = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH             = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET            = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH           = 12'hB82;
  localparam logic [11:0] CSR_CYCLE               = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH              = 12'hC80;
  localparam logic [11:0] CSR_INSTRET             = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH            = 12'hC82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT       = 12'h320;
  localparam logic [11:0] CSR_APPROX_BASE_DEFAULT = 12'h800;

  localparam int INHIBIT_CY_BIT = 0;
  localparam int INHIBIT_IR_BIT = 2;

  typedef enum logic [1:0] {
    WOP_WRITE = 2'b00,
    WOP_SET   = 2'b01,
    WOP_CLEAR = 2'b10,
    WOP_RSVD  = 2'b11
  } csr_wop_e;

  // Bitwise so it applies to any CSR width.
  function automatic logic csr_combine_bit(input csr_wop_e op,
                                           input logic     old_bit,
                                           input logic     data_bit);
    case (op)
      WOP_WRITE: return data_bit;
      WOP_SET:   return old_bit | data_bit;
      WOP_CLEAR: return old_bit & ~data_bit;
      default:   return old_bit;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// =====================================================================
// Module   : csr_counter64
// Brief    : Split-half counter; a half-write beats the increment/carry
// Revision : 1.0
// =====================================================================
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               wr_lo,
  input  logic               wr_hi,
  input  logic [WIDTH/2-1:0] wr_data,
  output logic [WIDTH-1:0]   count
);

  localparam int HALF = WIDTH / 2;

  logic [HALF-1:0] lo_q, lo_d;
  logic [HALF-1:0] hi_q, hi_d;
  logic            carry;

  always_comb begin
    // A low-half write suppresses the carry in the same cycle.
    carry = inc && !wr_lo && (&lo_q);
    lo_d  = lo_q;
    hi_d  = hi_q;
    if (wr_lo) begin
      lo_d = wr_data;
    end else if (inc) begin
      lo_d = lo_q + HALF'(1);
    end
    if (wr_hi) begin
      hi_d = wr_data;
    end else if (carry) begin
      hi_d = hi_q + HALF'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count = {hi_q, lo_q};

endmodule
`default_nettype wire

// File: rtl/csr_register_bank.sv
`default_nettype none
// =====================================================================
// Module   : csr_register_bank
// Brief    : Approximation-control CSRs plus mcycle/minstret counters.
//            Define MCOUNTINHIBIT_EN to add mcountinhibit at 0x320.
// Revision : 1.0
// =====================================================================
module csr_register_bank
  import csr_pkg::*;
#(
  parameter int          NUM_APPROX  = 3,
  parameter logic [11:0] APPROX_BASE = CSR_APPROX_BASE_DEFAULT,
  parameter int          XLEN        = 32,
  parameter int          CNT_WIDTH   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_enable,
  input  logic [11:0]                read_index,
  output logic [XLEN-1:0]            read_data,
  input  logic                       write_enable,
  input  logic [11:0]                write_index,
  input  logic [1:0]                 write_op,
  input  logic [XLEN-1:0]            write_data,
  input  logic                       instret,
  output logic                       illegal,
  output logic [NUM_APPROX*XLEN-1:0] approx_ctrl
);

  logic [NUM_APPROX-1:0][XLEN-1:0] approx_q, approx_d;
  logic [CNT_WIDTH-1:0]            mcycle, minstret;
  logic                            cy_inc, ir_inc;
  logic                            rd_hit, wr_ok, wr_commit;
  logic [XLEN-1:0]                 wr_old, wr_new;
  logic [11:0]                     wr_off;

`ifdef MCOUNTINHIBIT_EN
  logic inhibit_cy_q, inhibit_cy_d;
  logic inhibit_ir_q, inhibit_ir_d;
`endif

  function automatic logic is_approx(input logic [11:0] idx);
    logic [11:0] off;
    off = idx - APPROX_BASE;
    return off < 12'(NUM_APPROX);
  endfunction

  function automatic logic is_counter_rw(input logic [11:0] idx);
    return idx inside {CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
  endfunction

  function automatic logic is_writable(input logic [11:0] idx);
    logic w;
    w = is_approx(idx) || is_counter_rw(idx);
`ifdef MCOUNTINHIBIT_EN
    w = w || (idx == CSR_MCOUNTINHIBIT);
`endif
    return w;
  endfunction

  function automatic logic is_mapped(input logic [11:0] idx);
    return is_writable(idx) ||
           (idx inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH});
  endfunction

  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] idx);
    logic [XLEN-1:0] v;
    logic [11:0]     off;
    v   = '0;
    off = idx - APPROX_BASE;
    for (int i = 0; i < NUM_APPROX; i++) begin
      if (off == 12'(i)) v = approx_q[i];
    end
    case (idx)
      CSR_MCYCLE,    CSR_CYCLE:    v = mcycle[XLEN-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   v = mcycle[CNT_WIDTH-1:XLEN];
      CSR_MINSTRET,  CSR_INSTRET:  v = minstret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: v = minstret[CNT_WIDTH-1:XLEN];
`ifdef MCOUNTINHIBIT_EN
      CSR_MCOUNTINHIBIT: begin
        v[INHIBIT_CY_BIT] = inhibit_cy_q;
        v[INHIBIT_IR_BIT] = inhibit_ir_q;
      end
`endif
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    rd_hit    = is_mapped(read_index);
    wr_ok     = is_writable(write_index) && (write_op != WOP_RSVD);
    illegal   = (read_enable && !rd_hit) || (write_enable && !wr_ok);
    read_data = (read_enable && rd_hit) ? csr_value(read_index) : '0;
    // Any illegal condition in the cycle blocks the write.
    wr_commit = write_enable && !illegal;
    wr_old    = csr_value(write_index);
    wr_new    = '0;
    for (int i = 0; i < XLEN; i++) begin
      wr_new[i] = csr_combine_bit(csr_wop_e'(write_op), wr_old[i], write_data[i]);
    end
  end

  always_comb begin
    approx_d = approx_q;
    wr_off   = write_index - APPROX_BASE;
    for (int i = 0; i < NUM_APPROX; i++) begin
      if (wr_commit && (wr_off == 12'(i))) approx_d[i] = wr_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      approx_q <= '0;
    end else begin
      approx_q <= approx_d;
    end
  end

  assign approx_ctrl = approx_q;

`ifdef MCOUNTINHIBIT_EN
  always_comb begin
    inhibit_cy_d = inhibit_cy_q;
    inhibit_ir_d = inhibit_ir_q;
    if (wr_commit && (write_index == CSR_MCOUNTINHIBIT)) begin
      inhibit_cy_d = wr_new[INHIBIT_CY_BIT];
      inhibit_ir_d = wr_new[INHIBIT_IR_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inhibit_cy_q <= 1'b0;
      inhibit_ir_q <= 1'b0;
    end else begin
      inhibit_cy_q <= inhibit_cy_d;
      inhibit_ir_q <= inhibit_ir_d;
    end
  end

  assign cy_inc = ~inhibit_cy_q;
  assign ir_inc = instret & ~inhibit_ir_q;
`else
  assign cy_inc = 1'b1;
  assign ir_inc = instret;
`endif

  csr_counter64 #(
    .WIDTH (CNT_WIDTH)
  ) u_mcycle (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (cy_inc),
    .wr_lo   (wr_commit && (write_index == CSR_MCYCLE)),
    .wr_hi   (wr_commit && (write_index == CSR_MCYCLEH)),
    .wr_data (wr_new),
    .count   (mcycle)
  );

  csr_counter64 #(
    .WIDTH (CNT_WIDTH)
  ) u_minstret (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (ir_inc),
    .wr_lo   (wr_commit && (write_index == CSR_MINSTRET)),
    .wr_hi   (wr_commit && (write_index == CSR_MINSTRETH)),
    .wr_data (wr_new),
    .count   (minstret)
  );

endmodule
`default_nettype wire

// File: tb/tb_csr_register_bank.sv
`default_nettype none
// =====================================================================
// Module   : tb_csr_register_bank
// Brief    : Directed and random stimulus against a 64-bit counter model
// Revision : 1.0
// =====================================================================
module tb_csr_register_bank;

  localparam int NA = 3;
`ifdef MCOUNTINHIBIT_EN
  localparam bit INH = 1'b1;
`else
  localparam bit INH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             re, we, ir;
  logic [11:0]      ridx, widx;
  logic [1:0]       wop;
  logic [31:0]      wdata, rdata;
  logic             illegal;
  logic [NA*32-1:0] approx_ctrl;

  csr_register_bank #(
    .NUM_APPROX  (NA),
    .APPROX_BASE (12'h800),
    .XLEN        (32),
    .CNT_WIDTH   (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_enable  (re),
    .read_index   (ridx),
    .read_data    (rdata),
    .write_enable (we),
    .write_index  (widx),
    .write_op     (wop),
    .write_data   (wdata),
    .instret      (ir),
    .illegal      (illegal),
    .approx_ctrl  (approx_ctrl)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint unsigned m_cycle, m_instret;
  logic [31:0]     m_approx [NA];
  logic [2:0]      m_inhibit;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_approx(input logic [11:0] idx);
    return (int'(idx) >= 'h800) && (int'(idx) < 'h800 + NA);
  endfunction

  function automatic bit m_writable(input logic [11:0] idx);
    return m_is_approx(idx) || (idx inside {12'hB00, 12'hB80, 12'hB02, 12'hB82}) ||
           (INH && idx == 12'h320);
  endfunction

  function automatic bit m_readable(input logic [11:0] idx);
    return m_writable(idx) || (idx inside {12'hC00, 12'hC80, 12'hC02, 12'hC82});
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] idx);
    if (m_is_approx(idx)) return m_approx[int'(idx) - 'h800];
    case (idx)
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'h320:          return INH ? {29'd0, m_inhibit} : 32'd0;
      default:          return 32'd0;
    endcase
  endfunction

  function automatic bit m_illegal();
    return (re && !m_readable(ridx)) || (we && (!m_writable(widx) || wop == 2'b11));
  endfunction

  task automatic model_reset();
    m_cycle   = 0;
    m_instret = 0;
    m_inhibit = 3'b000;
    for (int k = 0; k < NA; k++) m_approx[k] = 32'd0;
  endtask

  // Counters as whole 64-bit values; a half write replaces that half.
  task automatic model_tick();
    longint unsigned nc, ni;
    logic [31:0]     old, nv;
    bit              inc_c, inc_i;
    inc_c = !(INH && m_inhibit[0]);
    inc_i = ir && !(INH && m_inhibit[2]);
    nc = m_cycle + 64'(inc_c);
    ni = m_instret + 64'(inc_i);
    if (we && !m_illegal()) begin
      old = m_read(widx);
      case (wop)
        2'b00:   nv = wdata;
        2'b01:   nv = old | wdata;
        default: nv = old & ~wdata;
      endcase
      if (m_is_approx(widx)) m_approx[int'(widx) - 'h800] = nv;
      case (widx)
        12'hB00: nc = {m_cycle[63:32], nv};
        12'hB80: nc = {nv, m_cycle[31:0] + 32'(inc_c)};
        12'hB02: ni = {m_instret[63:32], nv};
        12'hB82: ni = {nv, m_instret[31:0] + 32'(inc_i)};
        12'h320: m_inhibit = nv[2:0] & 3'b101;
        default: ;
      endcase
    end
    m_cycle   = nc;
    m_instret = ni;
  endtask

  task automatic drive(input bit r, input logic [11:0] ri, input bit w, input logic [11:0] wi,
                       input logic [1:0] o, input logic [31:0] d, input bit i);
    re = r; ridx = ri; we = w; widx = wi; wop = o; wdata = d; ir = i;
    #1;
    check_eq("read_data", 64'(rdata), (r && m_readable(ri)) ? 64'(m_read(ri)) : 64'd0);
    check_eq("illegal", 64'(illegal), 64'(m_illegal()));
    for (int k = 0; k < NA; k++)
      check_eq($sformatf("approx_ctrl[%0d]", k), 64'(approx_ctrl[k*32 +: 32]), 64'(m_approx[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic step(input bit r, input logic [11:0] ri, input bit w, input logic [11:0] wi,
                      input logic [1:0] o, input logic [31:0] d, input bit i);
    drive(r, ri, w, wi, o, d, i);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 12'h0, 0, 12'h0, 2'b00, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] frozen;
    logic [11:0] pool [16];
    logic [11:0] ri, wi;
    logic [31:0] d;

    pool = '{12'h800, 12'h801, 12'h802, 12'h803, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
             12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h320, 12'h7FF, 12'h810, 12'h000};

    reset = 1'b0;
    model_reset();
    #2;
    drive(1, 12'hB00, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("reset_mcycle", 64'(rdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    idle(10);
    drive(1, 12'hB00, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("mcycle_after_10", 64'(rdata), 64'd10);
    tick();
    drive(1, 12'hB80, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("mcycleh_zero", 64'(rdata), 64'd0);
    check_eq("approx_ctrl_zero", 64'(approx_ctrl[63:0]), 64'd0);
    tick();

    step(0, 12'h0, 1, 12'h801, 2'b00, 32'h0000_00F0, 0);
    step(1, 12'h801, 1, 12'h801, 2'b01, 32'h0000_000F, 0);
    drive(1, 12'h801, 1, 12'h801, 2'b10, 32'h0000_00F0, 0);
    check_eq("approx_set", 64'(rdata), 64'h0000_00FF);
    tick();
    drive(1, 12'h801, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("approx_clear", 64'(rdata), 64'h0000_000F);
    check_eq("approx_ctrl_hi", 64'(approx_ctrl[63:32]), 64'h0000_000F);
    tick();

    step(0, 12'h0, 1, 12'hB00, 2'b00, 32'hFFFF_FFFE, 0);
    step(0, 12'h0, 1, 12'hB80, 2'b00, 32'h0000_0001, 0);
    idle(1);
    drive(1, 12'hB80, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("wrap_high", 64'(rdata), 64'd2);
    tick();
    drive(1, 12'hC00, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("wrap_low_shadow", 64'(rdata), 64'd1);
    tick();

    drive(0, 12'h0, 1, 12'hC00, 2'b00, 32'h1234, 0);
    check_eq("ill_wr_ro", 64'(illegal), 64'd1);
    tick();
    drive(0, 12'h0, 1, 12'h810, 2'b00, 32'h1234, 0);
    check_eq("ill_wr_unmapped", 64'(illegal), 64'd1);
    tick();
    drive(1, 12'h7FF, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("ill_rd_data", 64'(rdata), 64'd0);
    check_eq("ill_rd_flag", 64'(illegal), 64'd1);
    tick();
    drive(0, 12'h0, 1, 12'h800, 2'b11, 32'hFFFF, 0);
    check_eq("ill_rsvd_op", 64'(illegal), 64'd1);
    tick();
    drive(1, 12'h800, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("rsvd_no_effect", 64'(rdata), 64'd0);
    tick();

    for (int c = 1; c <= 5; c++) step(0, 12'h0, c == 3, 12'hB02, 2'b00, 32'd100, 1);
    drive(1, 12'hB02, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("minstret_102", 64'(rdata), 64'd102);
    tick();
    drive(1, 12'hC82, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("instreth_zero", 64'(rdata), 64'd0);
    tick();

`ifdef MCOUNTINHIBIT_EN
    step(0, 12'h0, 1, 12'h320, 2'b00, 32'h1, 0);
    frozen = m_cycle[31:0];
    for (int c = 0; c < 8; c++) begin
      drive(1, 12'hB00, 0, 12'h0, 2'b00, 32'h0, 1);
      check_eq("mcycle_frozen", 64'(rdata), 64'(frozen));
      tick();
    end
    drive(1, 12'h320, 1, 12'h320, 2'b00, 32'h0, 0);
    check_eq("inhibit_readback", 64'(rdata), 64'd1);
    tick();
    idle(2);
    drive(1, 12'hB00, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("mcycle_resumed", 64'(rdata), 64'(frozen + 32'd2));
    tick();
`else
    drive(0, 12'h0, 1, 12'h320, 2'b00, 32'h1, 0);
    check_eq("ill_inhibit_absent", 64'(illegal), 64'd1);
    tick();
`endif

    // Asynchronous reset in the middle of a cycle with a write pending.
    drive(1, 12'h800, 1, 12'h800, 2'b00, 32'h0000_DEAD, 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_approx", 64'(approx_ctrl[31:0]), 64'd0);
    check_eq("async_rst_read", 64'(rdata), 64'd0);
    re = 0; we = 0; ir = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 12'h800, 0, 12'h0, 2'b00, 32'h0, 0);
    check_eq("rst_write_dropped", 64'(rdata), 64'd0);
    tick();

    for (int n = 0; n < 500; n++) begin
      ri = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 15)];
      wi = pool[$urandom_range(0, 15)];
      d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      step(1'($urandom_range(0, 1)), ri, ($urandom_range(0, 2) != 0), wi,
           2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_register_bank.md
Name: csr_register_bank

Overview:
- Parametrised successor to the core's control/status register file.
- Holds NUM_APPROX approximation control CSRs for the ALU, multiplier, divider and future units.
- Holds live 64-bit mcycle/minstret counters, plus user read-only shadows.
- Applies the CSR write operation (write/set/clear) internally and flags illegal accesses. Sits beside the execute stage and is read/written by the CSR instruction path.

Parameters:
- NUM_APPROX, 3, number of approximation control CSRs (1..16).
- APPROX_BASE, 12'h800, CSR index of approximation CSR 0; CSR i is at APPROX_BASE+i.
- XLEN, 32, CSR data width.
- CNT_WIDTH, 64, counter width (must be 2*XLEN).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- read_enable  in  1  read strobe
- read_index  in  12  CSR index to read
- read_data  out  XLEN  read value, combinational
- write_enable  in  1  write strobe
- write_index  in  12  CSR index to write
- write_op  in  2  00 write, 01 set (old|data), 10 clear (old&~data), 11 reserved (no effect)
- write_data  in  XLEN  operand for write_op
- instret  in  1  one-cycle pulse per retired instruction
- illegal  out  1  combinational: illegal access this cycle
- approx_ctrl  out  NUM_APPROX*XLEN  all approximation CSRs concatenated, CSR 0 in LSBs

Behaviour:
- Reset (reset=0, async): all approximation CSRs, mcycle and minstret = 0. approx_ctrl = 0. Combinational outputs follow the cleared state.
- Index map:
  - APPROX_BASE..+NUM_APPROX-1: read/write.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows of the same counters.
- Read:
  - read_data = selected value in the same cycle.
  - read_data = 0 when read_enable=0 or the index is unmapped (never high-Z).
  - A read in the same cycle as a write to that index returns the old value.
- Write:
  - new = f(write_op, current, write_data), committed at the next rising edge.
  - Low-half counter write replaces bits [31:0] only, with no carry into the high half that cycle.
  - High-half write replaces bits [63:32]; the low half continues counting normally.
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments by 1 on each cycle instret=1.
  - Both wrap from 2^64-1 to 0.
- Simultaneous write and increment on the same half: the write wins and the increment is dropped.
- Low-half wrap during a write to the high half: the write value is used, and the carry is dropped.
- illegal = 1 when any of the following holds; the write then has no effect:
  - read_enable with an unmapped index;
  - write_enable with an unmapped or read-only (0xCxx) index;
  - write_enable with write_op=11.
- Reset asserted mid-operation: state clears immediately; any pending write is discarded.

Optional Feature:
- Macro MCOUNTINHIBIT_EN.
- Defined:
  - Adds mcountinhibit at 0x320, read/write, reset 0.
  - Bit 0 = 1 freezes mcycle; bit 2 = 1 freezes minstret.
  - Other bits read 0 and ignore writes.
  - Explicit CSR writes to the counters still take effect while frozen.
- Undefined: 0x320 is unmapped (illegal), and the counters always run.

Decomposition:
- Shared package csr_pkg:
  - CSR index constants (counters, shadows, mcountinhibit, default APPROX_BASE);
  - write_op encodings;
  - the set/clear combine function.
- Sub-module csr_counter64: 64-bit counter with inc, wr_lo, wr_hi and data inputs, implementing the write-wins and no-carry rules. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then 10 idle cycles; read 0xB00 -> 10 (±1 per bench sampling convention); read 0xB80 -> 0; approx_ctrl = 0.
- Approximation CSR ops:
  - write 0x801 op=00 data 0x0000_00F0;
  - then op=01 data 0x0F -> read 0x801 = 0x0000_00FF;
  - then op=10 data 0xF0 -> 0x0000_000F; approx_ctrl[63:32] matches.
- Counter wrap:
  - write 0xB00 = 0xFFFF_FFFE and 0xB80 = 0x0000_0001 in consecutive cycles;
  - expected: {0xB80, 0xB00} reaches 0x0000_0002_0000_0000 two cycles after the low-half write.
- Write 0xC00 or 0x810 (NUM_APPROX=3) -> illegal=1, no state change; read 0x7FF -> read_data=0, illegal=1.
- Pulse instret on 5 cycles while simultaneously writing 0xB02=100 in cycle 3 -> final minstret = 102.
- MCOUNTINHIBIT_EN: write 0x320 = 0x1; mcycle holds constant for 8 cycles while minstret still counts; write 0x320 = 0 -> mcycle resumes.
